// File: rtl/cla_sum_stage.sv
`default_nettype none
// ============================================================================
// Module   : cla_sum_stage
// Summary  : Carry-lookahead adder final sum stage (s = p ^ carry-in per bit),
//            with valid pipeline, zero flag and block-propagate flag.
// Revision : 1.0 - initial release
// ============================================================================
module cla_sum_stage #(
   parameter int WIDTH   = 4,
   parameter bit REG_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             cin,
   input  logic [WIDTH-2:0] c,
   input  logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] s,
   output logic             out_valid,
   output logic             s_zero,
   output logic             blk_prop
);

   logic [WIDTH-1:0] s_d;
   logic             zero_d;
   logic             prop_d;

   // Carry into bit 0 is cin; carry into bit i>0 is c[i-1].
   assign s_d    = p ^ {c, cin};
   assign zero_d = ~|s_d;
   assign prop_d = &p;

   generate
      if (REG_OUT) begin : g_reg
         logic [WIDTH-1:0] s_q;
         logic             valid_q;
         logic             zero_q;
         logic             prop_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s_q     <= '0;
               valid_q <= 1'b0;
               zero_q  <= 1'b1;
               prop_q  <= 1'b0;
            end else begin
               s_q     <= s_d;
               valid_q <= in_valid;
               zero_q  <= zero_d;
               prop_q  <= prop_d;
            end
         end

         assign s         = s_q;
         assign out_valid = valid_q;
         assign s_zero    = zero_q;
         assign blk_prop  = prop_q;
      end else begin : g_comb
         // Clock and reset have no function in the combinational build.
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst_n;

         assign s         = s_d;
         assign out_valid = in_valid;
         assign s_zero    = zero_d;
         assign blk_prop  = prop_d;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cla_sum_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_sum_stage
// Summary  : Self-checking bench for cla_sum_stage, registered and
//            combinational builds side by side against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_sum_stage;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         cin;
   logic [W-2:0] c;
   logic [W-1:0] p;

   logic [W-1:0] s_r, s_c;
   logic         ov_r, ov_c, z_r, z_c, bp_r, bp_c;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cla_sum_stage #(.WIDTH(W), .REG_OUT(1'b1)) dut_r (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .cin(cin), .c(c), .p(p),
      .s(s_r), .out_valid(ov_r), .s_zero(z_r), .blk_prop(bp_r)
   );

   cla_sum_stage #(.WIDTH(W), .REG_OUT(1'b0)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .cin(cin), .c(c), .p(p),
      .s(s_c), .out_valid(ov_c), .s_zero(z_c), .blk_prop(bp_c)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Sum bit i is propagate i flipped by whatever carry enters bit i.
   function automatic int unsigned model_sum(input int unsigned pp, input int unsigned cc,
                                             input int unsigned ci);
      int unsigned carries_in;
      carries_in = (cc * 2) + ci;
      return (pp ^ carries_in) % (1 << W);
   endfunction

   // Compare process: registered build against last edge's inputs, comb build against now.
   initial begin
      int unsigned e_s;
      logic        e_v, e_z, e_bp;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            e_s = 0; e_v = 1'b0; e_z = 1'b1; e_bp = 1'b0;
         end else begin
            e_s  = model_sum(int'(p), int'(c), int'(cin));
            e_v  = in_valid;
            e_z  = (e_s == 0);
            e_bp = (p == (1 << W) - 1);
         end
         #1;
         chk("reg_s", s_r, e_s);
         chk("reg_valid", ov_r, e_v);
         chk("reg_zero", z_r, e_z);
         chk("reg_bprop", bp_r, e_bp);
         chk("comb_s", s_c, model_sum(int'(p), int'(c), int'(cin)));
         chk("comb_valid", ov_c, in_valid);
         chk("comb_zero", z_c, model_sum(int'(p), int'(c), int'(cin)) == 0);
         chk("comb_bprop", bp_c, p == (1 << W) - 1);
      end
   end

   // Drive one input set, pin the comb build immediately and the registered build after the edge.
   task automatic drive_chk(input logic v, input logic ci, input logic [W-2:0] cc,
                            input logic [W-1:0] pp, input logic [W-1:0] es,
                            input logic ez, input logic ebp);
      @(negedge clk);
      in_valid = v; cin = ci; c = cc; p = pp;
      #1;
      chk("lit_comb_s", s_c, es);
      chk("lit_comb_zero", z_c, ez);
      chk("lit_comb_bprop", bp_c, ebp);
      chk("lit_comb_valid", ov_c, v);
      @(posedge clk);
      #2;
      chk("lit_reg_s", s_r, es);
      chk("lit_reg_zero", z_r, ez);
      chk("lit_reg_bprop", bp_r, ebp);
      chk("lit_reg_valid", ov_r, v);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; cin = 1'b0; c = '0; p = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_s", s_r, 0);
      chk("rst_valid", ov_r, 0);
      chk("rst_zero", z_r, 1);
      chk("rst_bprop", bp_r, 0);
      @(negedge clk);
      rst_n = 1'b1;

      drive_chk(1'b1, 1'b0, 3'b000, 4'b0000, 4'b0000, 1'b1, 1'b0);
      drive_chk(1'b1, 1'b0, 3'b000, 4'b1111, 4'b1111, 1'b0, 1'b1);
      drive_chk(1'b1, 1'b1, 3'b111, 4'b0000, 4'b1111, 1'b0, 1'b0);
      drive_chk(1'b1, 1'b1, 3'b111, 4'b1111, 4'b0000, 1'b1, 1'b1);
      drive_chk(1'b1, 1'b1, 3'b010, 4'b0101, 4'b0000, 1'b1, 1'b0);
      drive_chk(1'b1, 1'b0, 3'b000, 4'b1010, 4'b1010, 1'b0, 1'b0);

      // Asynchronous reset mid-cycle must clear the registered outputs without an edge.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_s", s_r, 0);
      chk("async_rst_valid", ov_r, 0);
      chk("async_rst_zero", z_r, 1);
      chk("async_rst_bprop", bp_r, 0);
      @(negedge clk);
      rst_n = 1'b1;

      drive_chk(1'b1, 1'b0, 3'b001, 4'b0011, 4'b0001, 1'b0, 1'b0);
      drive_chk(1'b0, 1'b1, 3'b000, 4'b0110, 4'b0111, 1'b0, 1'b0);
      drive_chk(1'b1, 1'b0, 3'b100, 4'b1000, 4'b0000, 1'b1, 1'b0);
      drive_chk(1'b1, 1'b1, 3'b011, 4'b1111, 4'b1000, 1'b0, 1'b1);

      // Random traffic: half arbitrary p/c, half consistent with a real a+b+cin.
      for (int i = 0; i < 400; i++) begin
         int unsigned a, b, ci, tot;
         logic        add_mode;
         @(negedge clk);
         in_valid = 1'($urandom);
         add_mode = 1'($urandom);
         a  = $urandom_range(0, (1 << W) - 1);
         b  = $urandom_range(0, (1 << W) - 1);
         ci = $urandom_range(0, 1);
         if (add_mode) begin
            tot = a + b + ci;
            p   = W'(a ^ b);
            c   = (W-1)'(((tot ^ a ^ b) >> 1));
            cin = 1'(ci);
         end else begin
            p   = W'($urandom);
            c   = (W-1)'($urandom);
            cin = 1'($urandom);
            tot = 0;
         end
         if (add_mode) begin
            @(posedge clk);
            #2;
            chk("add_reg_s", s_r, tot % (1 << W));
         end
      end

      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
